stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised, registered N-input stream selector for the datapath mux library. It generalises the fixed-width 3-to-1 select mux to `NUM_IN` inputs of `WIDTH` bits, with valid/ready handshakes on every port. It has two modes: explicit select, and fair round-robin arbitration. A single output register decouples the selected input from the downstream consumer. It sits between multiple producers (ALU result, load data, immediate path) and one shared consumer.

## Interface
- `WIDTH`, 32, data width per channel
- `NUM_IN`, 3, number of input channels (2..16)
- `SEL_W`, 2, select/source index width; must satisfy 2**SEL_W >= NUM_IN

- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `mode`  input  1  0 = explicit select, 1 = round-robin
- `sel`  input  SEL_W  channel index used when mode=0
- `in_data`  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH]
- `in_valid`  input  NUM_IN  per-channel valid
- `in_ready`  output  NUM_IN  per-channel ready; at most one bit high
- `out_data`  output  WIDTH  registered selected word
- `out_valid`  output  1  out_data holds an unconsumed word
- `out_src`  output  SEL_W  index of the channel that supplied out_data
- `out_ready`  input  1  consumer accepts out_data

## Operation
- Output register state: `out_valid`, `out_data`, `out_src`. Round-robin pointer `last` (SEL_W bits).
- Load enable: `load_en = !out_valid || out_ready`. The register accepts a new word when it is empty or is being drained in the same cycle.
- Grant in mode=0:
  - If `sel < NUM_IN`, then g = sel and `in_ready[sel] = load_en`, independent of `in_valid`.
  - If `sel >= NUM_IN`, there is no grant and all `in_ready` bits are 0. This is the generalisation of the "unused select code yields nothing" rule.
- Grant in mode=1:
  - Scan channels `last+1, last+2, ... , last+NUM_IN`, all modulo NUM_IN.
  - g is the first channel with `in_valid` high, and `in_ready[g] = load_en`.
  - If no channel is valid, there is no grant.
- Transfer: occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - out_data <= channel g data
  - out_src <= g
  - out_valid <= 1
  - in mode=1 only, last <= g
- Drain without refill: `out_valid && out_ready` with no transfer gives out_valid <= 0. out_data and out_src hold their old values.
- No transfer and no drain: all registers hold.
- `last` updates only on a mode=1 transfer. It is preserved across mode switches.
- Mode and sel changes take effect on the combinational grant in the same cycle. A word already held in the output register is unaffected.
- Simultaneous drain and transfer in the same cycle: the new word replaces the old one and out_valid stays 1. Full throughput of one word per cycle is maintained.

## Timing
- Latency: one cycle from transfer edge to out_valid/out_data.
- Throughput: one word per cycle while out_ready stays high.
- `in_ready` is combinational from out_valid, out_ready, mode and sel, and in mode=1 also from in_valid. There is no combinational path from in_data to any output.
- Backpressure: out_valid=1 with out_ready=0 forces all in_ready bits to 0. out_data must stay stable until accepted.
- Reset values:
  - out_valid=0
  - out_data=0
  - out_src=0
  - last=NUM_IN-1, so the first round-robin grant prefers channel 0
- Reset mid-operation: any held word is discarded. in_ready is 0 during the reset cycle.

## Test plan
- Mode 0, NUM_IN=3, out_ready=1, all valid, data 32'hFFFFFFCB / 32'hFFFFFFB5 / 32'hFFFFFF47, sel stepped 0,1,2,3 → out_data follows one cycle later with out_src 0,1,2. With sel=3: in_ready=3'b000 and out_valid drops to 0.
- Mode 1, all three channels valid continuously, out_ready=1 → out_src sequence 0,1,2,0,1,2 with out_valid high every cycle.
- Mode 1, only channels 0 and 2 valid → grants alternate 0,2,0,2. Channel 1 is never granted.
- Backpressure: hold out_ready=0 for 4 cycles with the register full → out_data and out_src stable, in_ready=0. On release, the held word drains and the next word loads on the same edge.
- Switch from mode 1 (last=1) to mode 0 with sel=0, then back to mode 1 → the first round-robin grant is channel 2.
- Assert reset while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, out_src=0. The first subsequent round-robin grant is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// Registered N-input stream selector with explicit-select and round-robin modes.
// A single output register decouples the granted producer from the consumer.
module stream_mux_rr #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] chan [NUM_IN];
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic             xfer;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign load_en = !out_valid || out_ready;

    always_comb begin
        logic [SEL_W-1:0] cand;
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        if (!mode) begin
            // Out-of-range select codes grant nothing.
            if (32'(sel) < NUM_IN) begin
                grant_valid = 1'b1;
                grant       = sel;
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_IN; k++) begin
                cand = SEL_W'((32'(last) + k) % NUM_IN);
                if (!grant_valid && in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant       = cand;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant_valid && load_en && !reset) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last      <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= chan[grant];
            out_src   <= grant;
            if (mode) begin
                last <= grant;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised and directed bench for stream_mux_rr against a per-cycle behavioural model.
module tb_stream_mux_rr;
    localparam int W = 32;
    localparam int N = 3;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           mode;
    logic [S-1:0]   sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [S-1:0]   out_src;
    logic           out_ready;

    stream_mux_rr #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: contents of the output register and the round-robin history.
    bit          m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int          m_src  = 0;
    int          m_last = N - 1;
    logic [W-1:0] dat [N];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel that wins this cycle, or -1 when nothing is granted.
    function automatic int model_grant(input bit m, input int s, input bit [N-1:0] v, input int lst);
        if (!m) return (s < N) ? s : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input bit rst, input bit m, input int s, input bit [N-1:0] v, input bit ordy);
        int g;
        bit load;
        bit xf;
        logic [N-1:0] er;
        reset     = rst;
        mode      = m;
        sel       = s[S-1:0];
        in_valid  = v;
        out_ready = ordy;
        in_data   = {dat[2], dat[1], dat[0]};
        #1;
        load = !m_valid || ordy;
        g    = model_grant(m, s, v, m_last);
        er   = '0;
        xf   = 1'b0;
        if (!rst && load && g >= 0) begin
            er[g] = 1'b1;
            xf    = v[g];
        end
        check("in_ready", W'(in_ready), W'(er));
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_last  = N - 1;
        end else if (xf) begin
            m_valid = 1'b1;
            m_data  = dat[g];
            m_src   = g;
            if (m) m_last = g;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check("out_valid", W'(out_valid), W'(m_valid));
        check("out_src", W'(out_src), W'(m_src));
        check("out_data", out_data, m_data);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) dat[i] = $urandom;
    endtask

    initial begin
        dat[0] = 32'hFFFF_FFCB;
        dat[1] = 32'hFFFF_FFB5;
        dat[2] = 32'hFFFF_FF47;
        step(1, 0, 0, 3'b000, 1);
        check("reset_data", out_data, 32'h0);

        // Explicit select stepping through every code including the unused one.
        for (int s = 0; s < 4; s++) step(0, 0, s, 3'b111, 1);
        check("sel3_drop", W'(out_valid), 32'h0);

        // Round robin, all valid, then only channels 0 and 2.
        step(1, 0, 0, 3'b000, 1);
        for (int i = 0; i < 6; i++) begin
            randomize_data();
            step(0, 1, 0, 3'b111, 1);
            check("rr_all_seq", W'(out_src), W'(i % 3));
        end
        for (int i = 0; i < 4; i++) begin
            randomize_data();
            step(0, 1, 0, 3'b101, 1);
        end

        // Backpressure with a full register, then release.
        randomize_data();
        step(0, 0, 1, 3'b111, 1);
        for (int i = 0; i < 4; i++) begin
            randomize_data();
            step(0, 0, 2, 3'b111, 0);
        end
        step(0, 0, 2, 3'b111, 1);
        check("bp_release_src", W'(out_src), 32'h2);

        // Mode switch keeps the round-robin history.
        step(1, 0, 0, 3'b000, 1);
        step(0, 1, 0, 3'b011, 1);
        step(0, 1, 0, 3'b011, 1);
        step(0, 0, 0, 3'b111, 1);
        step(0, 1, 0, 3'b111, 1);
        check("rr_after_switch", W'(out_src), 32'h2);

        // Reset while stalled discards the word and restores the pointer.
        step(0, 0, 1, 3'b111, 1);
        step(0, 0, 1, 3'b111, 0);
        step(1, 1, 0, 3'b111, 0);
        step(0, 1, 0, 3'b111, 1);
        check("rr_after_reset", W'(out_src), 32'h0);

        for (int i = 0; i < 400; i++) begin
            randomize_data();
            step(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, 3)),
                 3'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1);
    end
endmodule
